// File: rtl/adder_pkg.sv
// adder_pkg: shared defaults, per-stage control record and chunk sizing for pipelined_adder
package adder_pkg;
   localparam int DEF_WIDTH  = 8;
   localparam int DEF_STAGES = 2;
   typedef struct packed {
      logic valid;
      logic carry;
      logic sub;
   } stage_t;
   function automatic int chunk_width(input int width, input int stages);
      return stages < 1 ? width : width / stages;
   endfunction
endpackage

// File: rtl/full_adder_cell.sv
// full_adder_cell: one-bit full adder
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: streaming ripple adder cut into STAGES carry segments; ADDSUB_EN adds a sub port
module pipelined_adder
   import adder_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef ADDSUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int C = chunk_width(WIDTH, STAGES);
   if (STAGES < 1 || WIDTH % STAGES != 0) begin : g_bad
      $error("pipelined_adder: WIDTH must be a multiple of STAGES >= 1");
   end
   stage_t ctl_q [STAGES];
   stage_t src_ctl [STAGES];
   logic [WIDTH-1:0] a_q [STAGES], b_q [STAGES], s_q [STAGES];
   logic [WIDTH-1:0] src_a [STAGES], src_b [STAGES], src_s [STAGES], s_d [STAGES];
   logic [WIDTH-1:0] ci, co, fs;
   logic sub_i, stall, ovf_q;
`ifdef ADDSUB_EN
   assign sub_i = sub;
`else
   assign sub_i = 1'b0;
`endif
   always_comb begin
      src_a[0]   = a;
      src_b[0]   = b;
      src_s[0]   = '0;
      src_ctl[0] = '{valid: in_valid, carry: cin | sub_i, sub: sub_i};
      for (int k = 1; k < STAGES; k++) begin
         src_a[k]   = a_q[k-1];
         src_b[k]   = b_q[k-1];
         src_s[k]   = s_q[k-1];
         src_ctl[k] = ctl_q[k-1];
      end
   end
   // each bit belongs to one stage; the first bit of a chunk takes that stage's registered carry
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      localparam int K = i / C;
      logic ci_b, co_b;
      if (i % C == 0) begin : g_lo
         assign ci_b = src_ctl[K].carry;
      end else begin : g_hi
         assign ci_b = g_bit[i-1].co_b;
      end
      full_adder_cell u_fa (
         .a (src_a[K][i]),
         .b (src_b[K][i] ^ src_ctl[K].sub),
         .ci(ci_b),
         .s (fs[i]),
         .co(co_b)
      );
      assign ci[i] = ci_b;
      assign co[i] = co_b;
   end
   always_comb begin
      for (int k = 0; k < STAGES; k++)
         for (int j = 0; j < WIDTH; j++)
            s_d[k][j] = (j / C == k) ? fs[j] : src_s[k][j];
   end
   assign stall     = ctl_q[STAGES-1].valid & ~out_ready;
   assign in_ready  = ~stall;
   assign out_valid = ctl_q[STAGES-1].valid;
   assign sum       = s_q[STAGES-1];
   assign cout      = ctl_q[STAGES-1].carry;
   assign ovf       = ovf_q;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int k = 0; k < STAGES; k++) begin
            ctl_q[k] <= '0;
            a_q[k]   <= '0;
            b_q[k]   <= '0;
            s_q[k]   <= '0;
         end
         ovf_q <= 1'b0;
      end else if (!stall) begin
         for (int k = 0; k < STAGES; k++) begin
            ctl_q[k] <= '{valid: src_ctl[k].valid, carry: co[(k+1)*C-1], sub: src_ctl[k].sub};
            a_q[k]   <= src_a[k];
            b_q[k]   <= src_b[k];
            s_q[k]   <= s_d[k];
         end
         ovf_q <= ci[WIDTH-1] ^ co[WIDTH-1];
      end
   end
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed checks at W=8/S=2 and an exhaustive run at W=4/S=4
module tb_pipelined_adder;
   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;
   logic iv8, ir8, ov8, or8, c8, co8, ovf8;
   logic [7:0] a8, b8, s8;
   logic iv4, ir4, ov4, or4, c4, co4, ovf4;
   logic [3:0] a4, b4, s4;
`ifdef ADDSUB_EN
   logic sub8 = 1'b0, sub4 = 1'b0;
`endif
   int checks = 0, errors = 0;
   int idx, got, cyc;
   logic [5:0] e;
   logic [4:0] t;
   logic [5:0] exp4 [$];
   pipelined_adder #(.WIDTH(8), .STAGES(2)) d8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(c8),
`ifdef ADDSUB_EN
      .sub(sub8),
`endif
      .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .ovf(ovf8)
   );
   pipelined_adder #(.WIDTH(4), .STAGES(4)) d4 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .cin(c4),
`ifdef ADDSUB_EN
      .sub(sub4),
`endif
      .out_valid(ov4), .out_ready(or4), .sum(s4), .cout(co4), .ovf(ovf4)
   );
   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   // exp = {ovf, cout, sum}
   task automatic op8(input string tag, input logic [7:0] x, input logic [7:0] y, input logic ci, input logic [9:0] exp);
      iv8 = 1'b1; a8 = x; b8 = y; c8 = ci;
      tick();
      iv8 = 1'b0;
      check({tag, "_pre"}, ov8, 0);
      tick();
      check({tag, "_valid"}, ov8, 1);
      check(tag, {ovf8, co8, s8}, exp);
      tick();
   endtask
   initial begin
      iv8 = 0; a8 = 0; b8 = 0; c8 = 0; or8 = 1;
      iv4 = 0; a4 = 0; b4 = 0; c4 = 0; or4 = 1;
      repeat (2) tick();
      rst_n = 1'b1;
      check("rst_valid", ov8, 0);
      check("rst_res", {ovf8, co8, s8}, 0);
      check("rst_ready", ir8, 1);
      check("rst_valid4", ov4, 0);
      op8("ff_01", 8'hFF, 8'h01, 1'b0, 10'h100);
      op8("7f_01", 8'h7F, 8'h01, 1'b0, 10'h280);
      op8("80_80", 8'h80, 8'h80, 1'b0, 10'h300);
      op8("12_34_c", 8'h12, 8'h34, 1'b1, 10'h047);
      op8("ff_ff_c", 8'hFF, 8'hFF, 1'b1, 10'h1FF);
`ifdef ADDSUB_EN
      sub8 = 1'b1;
      op8("sub_05_07", 8'h05, 8'h07, 1'b0, 10'h0FE);
      op8("sub_07_05", 8'h07, 8'h05, 1'b0, 10'h102);
      sub8 = 1'b0;
`endif
      or8 = 0; iv8 = 1; a8 = 8'h01; b8 = 8'h02; c8 = 0;
      tick();
      a8 = 8'h10; b8 = 8'h20;
      tick();
      a8 = 8'hAA; b8 = 8'hAA;
      check("bp_ready", ir8, 0);
      check("bp_first", {ov8, s8}, 9'h103);
      repeat (3) begin
         tick();
         check("bp_hold", {ov8, ir8, s8}, 10'h203);
      end
      iv8 = 0; or8 = 1;
      tick();
      check("bp_second", {ov8, s8}, 9'h130);
      tick();
      check("bp_drain", ov8, 0);
      or8 = 0; iv8 = 1; a8 = 8'h11; b8 = 8'h22;
      tick();
      a8 = 8'h33; b8 = 8'h44;
      tick();
      iv8 = 0; rst_n = 0;
      check("mid_inflight", ov8, 1);
      tick();
      check("mid_valid", ov8, 0);
      check("mid_res", {ovf8, co8, s8}, 0);
      rst_n = 1; or8 = 1;
      repeat (3) begin
         tick();
         check("mid_lost", ov8, 0);
      end
      idx = 0; got = 0; cyc = 0;
      while (got < 512 && cyc < 5000) begin
         iv4 = idx < 512;
         {a4, b4, c4} = idx[8:0];
         or4 = $urandom_range(0, 3) != 0;
         @(negedge clk);
         if (ov4 && or4) begin
            e = exp4.size() > 0 ? exp4.pop_front() : 6'bx;
            check("ex_res", {ovf4, co4, s4}, e);
            got++;
         end
         if (iv4 && ir4) begin
            t = {1'b0, a4} + {1'b0, b4} + {4'b0, c4};
            exp4.push_back({(a4[3] == b4[3]) && (t[3] != a4[3]), t});
            idx++;
         end
         tick();
         cyc++;
      end
      check("ex_count", got, 512);
      check("ex_left", exp4.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
